// File: rtl/mem_handshake_ram_pkg.sv
// mem_handshake_ram_pkg
// Shared definitions for the MFA/MFC handshake memory: access size codes,
// controller state codes, the alignment trap type, and the small pure
// helpers that decode alignment and extend read data.
// No ports; imported by mem_handshake_ram.

package mem_handshake_ram_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Trap type the CU raises when MemErr comes back with MFC.
   localparam logic [7:0] TT_MEM_ALIGN = 8'h07;

   // Only the two low address bits matter for alignment; the reserved
   // size code is always reported as an error.
   function automatic logic is_bad_access(size_e sz, logic [1:0] lo);
      logic bad;
      bad = 1'b1;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // The raw word is the big-endian fetch starting at the access address,
   // so a byte lives in [31:24] and a half in [31:16] before right-justifying.
   function automatic logic [31:0] extend_read(size_e sz, logic sext, logic [31:0] raw);
      logic [31:0] res;
      res = raw;
      case (sz)
         SZ_BYTE: res = {{24{sext & raw[31]}}, raw[31:24]};
         SZ_HALF: res = {{16{sext & raw[31]}}, raw[31:16]};
         default: res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_handshake_ram.sv
// mem_handshake_ram
// Byte-addressed big-endian main memory answering the datapath's MFA/MFC
// handshake. A request is latched in IDLE, waits WAIT_STATES cycles, then
// the access is performed on the edge that enters DONE. MFC is held until
// MFA drops. Misaligned or reserved-size accesses complete with MemErr and
// touch neither storage nor DataOut.
// Ports:
//   Clk       rising-edge clock
//   Reset     asynchronous active-low reset
//   MFA       request, held high until MFC is seen
//   RW        1 = read, 0 = write
//   MOP_SIZE  00 byte, 01 half, 10 word, 11 reserved
//   SignExt   reads only: sign- (1) or zero- (0) extend byte/half
//   Addr      byte address, only Addr[AW-1:0] used
//   DataIn    right-justified write data
//   DataOut   registered, right-justified, extended read data
//   MFC       memory function complete
//   MemErr    alignment / size error, valid with MFC

module mem_handshake_ram
   import mem_handshake_ram_pkg::*;
#(
   parameter int DEPTH_BYTES = 512,
   parameter int AW          = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MFA,
   input  logic        RW,
   input  logic [1:0]  MOP_SIZE,
   input  logic        SignExt,
   input  logic [31:0] Addr,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        MFC,
   output logic        MemErr
);

   logic [7:0] ram [0:DEPTH_BYTES-1];

   state_e         state_q, state_d;
   logic [3:0]     count_q, count_d;
   logic           rw_q, rw_d;
   logic [1:0]     size_q, size_d;
   logic           sext_q, sext_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           mfc_q, mfc_d;
   logic           err_q, err_d;
   logic [31:0]    dout_q, dout_d;

   logic           op_rw;
   size_e          op_size;
   logic           op_sext;
   logic [AW-1:0]  op_addr;
   logic [31:0]    op_wdata;
   logic [AW-1:0]  a1, a2, a3;
   logic [31:0]    rd_raw;
   logic           do_access;
   logic           bad;
   logic           ram_we;

   logic           unused_addr_bits;
   assign unused_addr_bits = ^Addr[31:AW];

   // With zero wait states the access happens on the accept edge itself,
   // before the latches hold the request, so the operands come straight
   // from the ports while in IDLE and from the latches otherwise.
   always_comb begin
      if (state_q == S_IDLE) begin
         op_rw    = RW;
         op_size  = size_e'(MOP_SIZE);
         op_sext  = SignExt;
         op_addr  = Addr[AW-1:0];
         op_wdata = DataIn;
      end else begin
         op_rw    = rw_q;
         op_size  = size_e'(size_q);
         op_sext  = sext_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
      end
      a1     = op_addr + AW'(1);
      a2     = op_addr + AW'(2);
      a3     = op_addr + AW'(3);
      rd_raw = {ram[op_addr], ram[a1], ram[a2], ram[a3]};
      bad    = is_bad_access(op_size, op_addr[1:0]);
   end

   // Handshake FSM. The counter is loaded with WAIT_STATES and DONE is
   // entered on the edge that finds it at zero, which gives MFC exactly
   // WAIT_STATES + 1 edges after the accepting edge.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rw_d      = rw_q;
      size_d    = size_q;
      sext_d    = sext_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mfc_d     = mfc_q;
      err_d     = err_q;
      dout_d    = dout_q;
      do_access = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (MFA) begin
               rw_d    = RW;
               size_d  = MOP_SIZE;
               sext_d  = SignExt;
               addr_d  = Addr[AW-1:0];
               wdata_d = DataIn;
               count_d = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d   = S_DONE;
                  do_access = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!MFA) begin
               state_d = S_IDLE;
               count_d = 4'd0;
            end else if (count_q == 4'd0) begin
               state_d   = S_DONE;
               do_access = 1'b1;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         S_DONE: begin
            if (!MFA) begin
               state_d = S_IDLE;
               mfc_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (do_access) begin
         mfc_d = 1'b1;
         err_d = bad;
         if (!bad && op_rw) begin
            dout_d = extend_read(op_size, op_sext, rd_raw);
         end
      end
      ram_we = do_access && !bad && !op_rw;
   end

   // Control and output registers; reset clears everything but storage.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         count_q <= 4'd0;
         rw_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         mfc_q   <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rw_q    <= rw_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mfc_q   <= mfc_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   // Storage is never reset. A write commits only on the DONE entry edge,
   // so an asynchronous reset during WAIT discards it.
   always_ff @(posedge Clk) begin
      if (ram_we) begin
         case (op_size)
            SZ_BYTE: begin
               ram[op_addr] <= op_wdata[7:0];
            end
            SZ_HALF: begin
               ram[op_addr] <= op_wdata[15:8];
               ram[a1]      <= op_wdata[7:0];
            end
            SZ_WORD: begin
               ram[op_addr] <= op_wdata[31:24];
               ram[a1]      <= op_wdata[23:16];
               ram[a2]      <= op_wdata[15:8];
               ram[a3]      <= op_wdata[7:0];
            end
            default: begin
            end
         endcase
      end
   end

   assign DataOut = dout_q;
   assign MFC     = mfc_q;
   assign MemErr  = err_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// tb_mem_handshake_ram
// Directed bench for mem_handshake_ram. The driver issues handshakes and
// pushes the hand-computed response into a scoreboard queue; a monitor
// pops and compares whenever MFC rises, including the MFC latency.

module tb_mem_handshake_ram;

   logic        Clk;
   logic        Reset;
   logic        MFA;
   logic        RW;
   logic [1:0]  MOP_SIZE;
   logic        SignExt;
   logic [31:0] Addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MFC;
   logic        MemErr;

   typedef struct {
      logic [31:0] dout;
      logic        err;
      int          issue_edge;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   vectors_applied = 0;
   int   miscompares     = 0;
   int   edge_count      = 0;
   logic mfc_prev        = 1'b0;

   localparam int LATENCY = 3;

   mem_handshake_ram #(
      .DEPTH_BYTES(512),
      .AW(9),
      .WAIT_STATES(2)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .MFA(MFA),
      .RW(RW),
      .MOP_SIZE(MOP_SIZE),
      .SignExt(SignExt),
      .Addr(Addr),
      .DataIn(DataIn),
      .DataOut(DataOut),
      .MFC(MFC),
      .MemErr(MemErr)
   );

   // 10 ns clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Edge counter used to measure request-to-MFC latency
   always @(posedge Clk) edge_count++;

   // One comparison: counts it and reports a miscompare
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors_applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every rising MFC must match the head of the scoreboard
   always @(negedge Clk) begin
      if (MFC && !mfc_prev) begin
         if (sb_q.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL unexpected_mfc: got MFC=1 with empty scoreboard, expected no completion");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput({e.name, "_dout"}, DataOut, e.dout);
            checkOutput({e.name, "_err"}, {31'd0, MemErr}, {31'd0, e.err});
            checkOutput({e.name, "_latency"}, 32'(edge_count - e.issue_edge), 32'(LATENCY));
         end
      end
      mfc_prev = MFC;
   end

   // Full handshake; called and returns at a negedge. Holds MFA for
   // `hold` extra cycles after MFC (toggling DataIn to prove the request
   // was latched), then drops MFA for exactly one edge.
   task automatic applyStimulus(input string name, input logic rw, input logic [1:0] sz,
                                input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_dout, input logic exp_err, input int hold);
      exp_t e;
      int   t;
      RW       = rw;
      MOP_SIZE = sz;
      SignExt  = sext;
      Addr     = addr;
      DataIn   = wdata;
      MFA      = 1'b1;
      e.dout       = exp_dout;
      e.err        = exp_err;
      e.issue_edge = edge_count + 1;
      e.name       = name;
      sb_q.push_back(e);
      t = 0;
      @(negedge Clk);
      while (!MFC && t < 20) begin
         @(negedge Clk);
         t++;
      end
      if (!MFC) begin
         vectors_applied++;
         miscompares++;
         $display("[TB] FAIL %s_timeout: got no MFC in 20 cycles, expected MFC", name);
      end
      for (int i = 0; i < hold; i++) begin
         DataIn   = ~DataIn;
         Addr     = Addr + 32'd1;
         @(negedge Clk);
         checkOutput({name, "_hold_mfc"}, {31'd0, MFC}, 32'd1);
      end
      MFA = 1'b0;
      @(negedge Clk);
      checkOutput({name, "_clr_mfc"}, {31'd0, MFC}, 32'd0);
      checkOutput({name, "_clr_err"}, {31'd0, MemErr}, 32'd0);
   endtask

   // Request that is withdrawn while still waiting: must never complete
   task automatic abortRequest(input logic [31:0] addr, input logic [31:0] wdata);
      RW       = 1'b0;
      MOP_SIZE = 2'b10;
      SignExt  = 1'b0;
      Addr     = addr;
      DataIn   = wdata;
      MFA      = 1'b1;
      @(negedge Clk);
      MFA = 1'b0;
      repeat (4) @(negedge Clk);
      checkOutput("abort_mfc", {31'd0, MFC}, 32'd0);
   endtask

   // Write interrupted by reset during WAIT
   task automatic resetMidWrite();
      RW       = 1'b0;
      MOP_SIZE = 2'b10;
      SignExt  = 1'b0;
      Addr     = 32'd8;
      DataIn   = 32'h11223344;
      MFA      = 1'b1;
      @(negedge Clk);
      #1 Reset = 1'b0;
      #1;
      checkOutput("rst_mid_mfc", {31'd0, MFC}, 32'd0);
      checkOutput("rst_mid_dout", DataOut, 32'd0);
      MFA = 1'b0;
      repeat (4) @(negedge Clk);
      checkOutput("rst_mid_hold_mfc", {31'd0, MFC}, 32'd0);
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   initial begin
      int t;
      Reset    = 1'b0;
      MFA      = 1'b0;
      RW       = 1'b0;
      MOP_SIZE = 2'b00;
      SignExt  = 1'b0;
      Addr     = 32'd0;
      DataIn   = 32'd0;
      repeat (3) @(negedge Clk);
      checkOutput("reset_dout", DataOut, 32'd0);
      checkOutput("reset_mfc", {31'd0, MFC}, 32'd0);
      checkOutput("reset_err", {31'd0, MemErr}, 32'd0);
      Reset = 1'b1;
      @(negedge Clk);

      // preload through the write path
      applyStimulus("w_word0",  1'b0, 2'b10, 1'b0, 32'd0, 32'h9C044012, 32'h00000000, 1'b0, 0);
      applyStimulus("w_word4",  1'b0, 2'b10, 1'b0, 32'd4, 32'h55667788, 32'h00000000, 1'b0, 0);
      applyStimulus("w_word8",  1'b0, 2'b10, 1'b0, 32'd8, 32'hA1B2C3D4, 32'h00000000, 1'b0, 0);

      // reads with extension
      applyStimulus("r_word0",   1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 32'h9C044012, 1'b0, 0);
      applyStimulus("r_byte0_s", 1'b1, 2'b00, 1'b1, 32'd0, 32'd0, 32'hFFFFFF9C, 1'b0, 0);
      applyStimulus("r_byte0_z", 1'b1, 2'b00, 1'b0, 32'd0, 32'd0, 32'h0000009C, 1'b0, 0);
      applyStimulus("r_half2_s", 1'b1, 2'b01, 1'b1, 32'd2, 32'd0, 32'h00004012, 1'b0, 0);

      // half write leaves neighbours and DataOut alone
      applyStimulus("w_half6",  1'b0, 2'b01, 1'b0, 32'd6, 32'hDEADBEEF, 32'h00004012, 1'b0, 0);
      applyStimulus("r_word4",  1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 32'h5566BEEF, 1'b0, 0);

      // alignment / reserved-size errors
      applyStimulus("e_rword2", 1'b1, 2'b10, 1'b0, 32'd2, 32'd0, 32'h5566BEEF, 1'b1, 0);
      applyStimulus("e_rsvd0",  1'b1, 2'b11, 1'b0, 32'd0, 32'd0, 32'h5566BEEF, 1'b1, 0);
      applyStimulus("e_wword1", 1'b0, 2'b10, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h5566BEEF, 1'b1, 0);
      applyStimulus("e_whalf5", 1'b0, 2'b01, 1'b0, 32'd5, 32'h0000FFFF, 32'h5566BEEF, 1'b1, 0);
      applyStimulus("r_word0b", 1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 32'h9C044012, 1'b0, 0);
      applyStimulus("r_word4b", 1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 32'h5566BEEF, 1'b0, 0);
      applyStimulus("r_byte1_z", 1'b1, 2'b00, 1'b0, 32'd1, 32'd0, 32'h00000004, 1'b0, 0);
      applyStimulus("r_byte3_s", 1'b1, 2'b00, 1'b1, 32'd3, 32'd0, 32'h00000012, 1'b0, 0);

      // upper address bits ignored
      applyStimulus("r_wrap",   1'b1, 2'b10, 1'b0, 32'hFFFFFE04, 32'd0, 32'h5566BEEF, 1'b0, 0);

      // withdrawn write commits nothing
      abortRequest(32'd4, 32'hFFFFFFFF);
      applyStimulus("r_half4_z", 1'b1, 2'b01, 1'b0, 32'd4, 32'd0, 32'h00005566, 1'b0, 0);

      // reset during WAIT discards the write
      resetMidWrite();
      applyStimulus("r_word8",  1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 32'hA1B2C3D4, 1'b0, 0);

      // long MFA hold: a single latched write
      applyStimulus("w_word12", 1'b0, 2'b10, 1'b0, 32'd12, 32'h01020304, 32'hA1B2C3D4, 1'b0, 0);
      applyStimulus("w_byte12_hold", 1'b0, 2'b00, 1'b0, 32'd12, 32'h000000A5, 32'hA1B2C3D4, 1'b0, 5);
      applyStimulus("r_word12",  1'b1, 2'b10, 1'b0, 32'd12, 32'd0, 32'hA5020304, 1'b0, 0);
      applyStimulus("r_byte12_s", 1'b1, 2'b00, 1'b1, 32'd12, 32'd0, 32'hFFFFFFA5, 1'b0, 0);
      applyStimulus("r_half12_z", 1'b1, 2'b01, 1'b0, 32'd12, 32'd0, 32'h0000A502, 1'b0, 0);
      applyStimulus("r_half12_s", 1'b1, 2'b01, 1'b1, 32'd12, 32'd0, 32'hFFFFA502, 1'b0, 0);

      t = 0;
      while (sb_q.size() != 0 && t < 20) begin
         @(negedge Clk);
         t++;
      end
      if (sb_q.size() != 0) begin
         vectors_applied++;
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
